// File: rtl/std_mshr_file_if.sv
// std_mshr_file_if: allocation, lookup, issue and retire signals of the MSHR file.
// master drives requests (core/miss handler side), slave is the MSHR file itself.
interface std_mshr_file_if #(
    parameter int NR_ENTRIES = 4,
    parameter int ADDR_WIDTH = 56,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
);
    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic                  alloc_valid_i;
    logic                  alloc_ready_o;
    logic [ID_WIDTH-1:0]   alloc_id_i;
    logic                  alloc_we_i;
    logic [ADDR_WIDTH-1:0] alloc_addr_i;
    logic [DATA_WIDTH-1:0] alloc_wdata_i;
    logic [BE_W-1:0]       alloc_be_i;
    logic                  alloc_make_unique_i;
    logic [IDX_W-1:0]      alloc_idx_o;

    logic [ADDR_WIDTH-1:0] lookup_addr_i;
    logic                  lookup_hit_o;
    logic [IDX_W-1:0]      lookup_idx_o;

    logic                  issue_valid_o;
    logic                  issue_ready_i;
    logic [IDX_W-1:0]      issue_idx_o;
    logic [ID_WIDTH-1:0]   issue_id_o;
    logic                  issue_we_o;
    logic [ADDR_WIDTH-1:0] issue_addr_o;
    logic [DATA_WIDTH-1:0] issue_wdata_o;
    logic [BE_W-1:0]       issue_be_o;
    logic                  issue_make_unique_o;

    logic                  retire_valid_i;
    logic [IDX_W-1:0]      retire_idx_i;

    logic [IDX_W:0]        occupancy_o;
    logic                  full_o;
    logic                  empty_o;

    modport master (
        output alloc_valid_i, alloc_id_i, alloc_we_i, alloc_addr_i,
        output alloc_wdata_i, alloc_be_i, alloc_make_unique_i,
        output lookup_addr_i, issue_ready_i, retire_valid_i, retire_idx_i,
        input  alloc_ready_o, alloc_idx_o, lookup_hit_o, lookup_idx_o,
        input  issue_valid_o, issue_idx_o, issue_id_o, issue_we_o,
        input  issue_addr_o, issue_wdata_o, issue_be_o, issue_make_unique_o,
        input  occupancy_o, full_o, empty_o
    );

    modport slave (
        input  alloc_valid_i, alloc_id_i, alloc_we_i, alloc_addr_i,
        input  alloc_wdata_i, alloc_be_i, alloc_make_unique_i,
        input  lookup_addr_i, issue_ready_i, retire_valid_i, retire_idx_i,
        output alloc_ready_o, alloc_idx_o, lookup_hit_o, lookup_idx_o,
        output issue_valid_o, issue_idx_o, issue_id_o, issue_we_o,
        output issue_addr_o, issue_wdata_o, issue_be_o, issue_make_unique_o,
        output occupancy_o, full_o, empty_o
    );
endinterface

// File: rtl/std_mshr_file.sv
// std_mshr_file: miss-status holding registers with line-conflict lookup and in-order issue.
// Ports: clk_i, rst_i (async, active-high), bus (std_mshr_file_if.slave).
module std_mshr_file #(
    parameter int NR_ENTRIES  = 4,
    parameter int ADDR_WIDTH  = 56,
    parameter int DATA_WIDTH  = 64,
    parameter int ID_WIDTH    = 2,
    parameter int LINE_OFFSET = 4
) (
    input logic            clk_i,
    input logic            rst_i,
    std_mshr_file_if.slave bus
);
    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        ISSUED  = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
        logic                  make_unique;
    } entry_t;

    state_e           st_q   [NR_ENTRIES];
    entry_t           ent_q  [NR_ENTRIES];
    logic [IDX_W-1:0] fifo_q [NR_ENTRIES];
    logic [IDX_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] cnt_q, occ_q;

    logic             alloc_hit, lookup_hit, full, push, pop;
    logic             retire_ok, retire_bad;
    logic [IDX_W-1:0] lookup_idx, free_idx, head_idx;
    logic [CNT_W-1:0] popcnt;
    entry_t           alloc_ent, head_ent;
    logic             unused_lookup_lsb;

    assign unused_lookup_lsb = ^bus.lookup_addr_i[LINE_OFFSET-1:0];

    // Descending scan so the lowest matching/free index is the last one written.
    always_comb begin
        alloc_hit  = 1'b0;
        lookup_hit = 1'b0;
        lookup_idx = '0;
        free_idx   = '0;
        popcnt     = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (st_q[i] != FREE) begin
                popcnt = popcnt + CNT_W'(1);
                if (ent_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] ==
                    bus.alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET])
                    alloc_hit = 1'b1;
                if (ent_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] ==
                    bus.lookup_addr_i[ADDR_WIDTH-1:LINE_OFFSET]) begin
                    lookup_hit = 1'b1;
                    lookup_idx = IDX_W'(i);
                end
            end else begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_ent = '{
        id:          bus.alloc_id_i,
        we:          bus.alloc_we_i,
        addr:        bus.alloc_addr_i,
        wdata:       bus.alloc_wdata_i,
        be:          bus.alloc_be_i,
        make_unique: bus.alloc_make_unique_i
    };

    assign full       = (occ_q == CNT_W'(NR_ENTRIES));
    assign head_idx   = fifo_q[head_q];
    assign head_ent   = ent_q[head_idx];
    assign push       = bus.alloc_valid_i && bus.alloc_ready_o;
    assign pop        = bus.issue_valid_o && bus.issue_ready_i;
    assign retire_ok  = bus.retire_valid_i && (st_q[bus.retire_idx_i] == ISSUED);
    assign retire_bad = bus.retire_valid_i && (st_q[bus.retire_idx_i] != ISSUED);

    assign bus.alloc_ready_o       = !full && !alloc_hit;
    assign bus.alloc_idx_o         = free_idx;
    assign bus.lookup_hit_o        = lookup_hit;
    assign bus.lookup_idx_o        = lookup_idx;
    assign bus.issue_valid_o       = (cnt_q != '0);
    assign bus.issue_idx_o         = head_idx;
    assign bus.issue_id_o          = head_ent.id;
    assign bus.issue_we_o          = head_ent.we;
    assign bus.issue_addr_o        = head_ent.addr;
    assign bus.issue_wdata_o       = head_ent.wdata;
    assign bus.issue_be_o          = head_ent.be;
    assign bus.issue_make_unique_o = head_ent.make_unique;
    assign bus.occupancy_o         = occ_q;
    assign bus.full_o              = full;
    assign bus.empty_o             = (occ_q == '0);

    // Alloc, pop and retire always target distinct entries (FREE,
    // PENDING, ISSUED respectively), so their writes never collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                st_q[i]   <= FREE;
                ent_q[i]  <= '0;
                fifo_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            occ_q  <= '0;
        end else begin
            if (retire_ok)
                st_q[bus.retire_idx_i] <= FREE;
            if (pop) begin
                st_q[head_idx] <= ISSUED;
                head_q         <= head_q + IDX_W'(1);
            end
            if (push) begin
                st_q[free_idx]  <= PENDING;
                ent_q[free_idx] <= alloc_ent;
                fifo_q[tail_q]  <= free_idx;
                tail_q          <= tail_q + IDX_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(retire_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!retire_bad)
            else $warning("std_mshr_file: retire of non-issued entry %0d ignored",
                          bus.retire_idx_i);
            assert (!(push && !pop && cnt_q == CNT_W'(NR_ENTRIES)))
            else $error("std_mshr_file: issue queue overflow");
            assert (occ_q == popcnt)
            else $error("std_mshr_file: occupancy %0d != live entries %0d",
                        occ_q, popcnt);
        end
    end
endmodule
